dcache: RTL and testbench

- Direct-mapped, write-back, write-allocate data cache between the CPU datapath and a 32-bit-word data memory.
- Geometry: 8 blocks × 4 bytes.
- CPU side is byte-wide with an 8-bit address; memory side is block-wide with a 6-bit block address.
- Stalls the CPU through BUSYWAIT on a miss or while a dirty-block write-back is in progress.

---
 rtl/dcache_pkg.sv | 17 +
 rtl/dcache_ctrl_fsm.sv | 51 +++++
 rtl/dcache.sv | 93 +++++++++
 tb/tb_dcache.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared types and geometry for the direct-mapped data cache.
// 8 lines x 4 bytes: 3-bit tag, 3-bit index, 2-bit offset.
package dcache_pkg;

  localparam int TAG_W = 3;
  localparam int IDX_W = 3;
  localparam int OFF_W = 2;
  localparam int BLK_W = 32;
  localparam int LINES = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MEM_WRITE = 2'd1,
    MEM_READ  = 2'd2
  } state_t;

endpackage

// File: rtl/dcache_ctrl_fsm.sv
// Cache controller: sequences write-back and refill transfers and
// produces the stall plus the strobes that update the line arrays.
module dcache_ctrl_fsm
  import dcache_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic read,
  input  logic write,
  input  logic hit,
  input  logic line_dirty,
  input  logic mem_busywait,
  output logic busywait,
  output logic mem_read,
  output logic mem_write,
  output logic refill_en,
  output logic wb_done,
  output logic write_en
);

  state_t state, next_state;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // A miss on a dirty line must write the old block back before refilling.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if ((read || write) && !hit)
          next_state = line_dirty ? MEM_WRITE : MEM_READ;
      end
      MEM_WRITE: if (!mem_busywait) next_state = MEM_READ;
      MEM_READ:  if (!mem_busywait) next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  always_comb begin
    busywait  = (read || write) && !(state == IDLE && hit);
    mem_read  = (state == MEM_READ);
    mem_write = (state == MEM_WRITE);
    refill_en = (state == MEM_READ) && !mem_busywait;
    wb_done   = (state == MEM_WRITE) && !mem_busywait;
    write_en  = (state == IDLE) && hit && write;
  end

endmodule

// File: rtl/dcache.sv
// Direct-mapped, write-back, write-allocate data cache between the CPU
// byte interface and a block-wide data memory.
module dcache
  import dcache_pkg::*;
(
  output logic        BUSYWAIT,
  input  logic        READ,
  input  logic        WRITE,
  input  logic [7:0]  WRITEDATA,
  output logic [7:0]  READDATA,
  input  logic [7:0]  ADDRESS,
  input  logic [31:0] PC,
  input  logic        RESET,
  input  logic        CLK,
  input  logic        mem_busywait,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_writedata,
  input  logic [31:0] mem_readdata,
  output logic [5:0]  mem_address
);

  logic [LINES-1:0] valid;
  logic [LINES-1:0] dirty;
  logic [TAG_W-1:0] tag  [LINES];
  logic [BLK_W-1:0] data [LINES];

  logic [TAG_W-1:0] addr_tag;
  logic [IDX_W-1:0] idx;
  logic [OFF_W-1:0] off;
  logic             hit;
  logic             refill_en;
  logic             wb_done;
  logic             write_en;
  logic             unused_pc;

  assign addr_tag  = ADDRESS[7:5];
  assign idx       = ADDRESS[4:2];
  assign off       = ADDRESS[1:0];
  assign hit       = valid[idx] && (tag[idx] == addr_tag);
  assign READDATA  = data[idx][{off, 3'b000} +: 8];
  assign unused_pc = ^PC;

  dcache_ctrl_fsm u_ctrl (
    .clk          (CLK),
    .reset        (RESET),
    .read         (READ),
    .write        (WRITE),
    .hit          (hit),
    .line_dirty   (valid[idx] && dirty[idx]),
    .mem_busywait (mem_busywait),
    .busywait     (BUSYWAIT),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .refill_en    (refill_en),
    .wb_done      (wb_done),
    .write_en     (write_en)
  );

  // Write-back targets the resident block; refill targets the requested one.
  always_comb begin
    mem_address   = '0;
    mem_writedata = '0;
    if (mem_write) begin
      mem_address   = {tag[idx], idx};
      mem_writedata = data[idx];
    end else if (mem_read) begin
      mem_address = ADDRESS[7:2];
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      valid <= '0;
      dirty <= '0;
      for (int i = 0; i < LINES; i++) begin
        tag[i]  <= '0;
        data[i] <= '0;
      end
    end else if (refill_en) begin
      data[idx]  <= mem_readdata;
      tag[idx]   <= addr_tag;
      valid[idx] <= 1'b1;
      dirty[idx] <= 1'b0;
    end else if (wb_done) begin
      dirty[idx] <= 1'b0;
    end else if (write_en) begin
      data[idx][{off, 3'b000} +: 8] <= WRITEDATA;
      dirty[idx]                    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dcache.sv
// Directed bench for dcache: memory model with a 5-cycle busy window,
// scoreboard queues for memory transfers and loaded bytes.
module tb_dcache;

  logic        BUSYWAIT;
  logic        READ;
  logic        WRITE;
  logic [7:0]  WRITEDATA;
  logic [7:0]  READDATA;
  logic [7:0]  ADDRESS;
  logic [31:0] PC;
  logic        RESET;
  logic        CLK;
  logic        mem_busywait;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;
  logic [5:0]  mem_address;

  typedef struct {
    logic        wr;
    logic [5:0]  addr;
    logic [31:0] data;
  } mem_txn_t;

  mem_txn_t    mem_q[$];
  logic [7:0]  rd_q[$];
  logic [31:0] mem_model [64];
  int          busy_cnt;
  int          checks;
  int          errors;

  dcache dut (
    .BUSYWAIT      (BUSYWAIT),
    .READ          (READ),
    .WRITE         (WRITE),
    .WRITEDATA     (WRITEDATA),
    .READDATA      (READDATA),
    .ADDRESS       (ADDRESS),
    .PC            (PC),
    .RESET         (RESET),
    .CLK           (CLK),
    .mem_busywait  (mem_busywait),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_writedata (mem_writedata),
    .mem_readdata  (mem_readdata),
    .mem_address   (mem_address)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Memory is busy for five cycles of each request, then completes.
  assign mem_busywait = (mem_read || mem_write) && (busy_cnt < 5);
  assign mem_readdata = mem_model[mem_address];

  always @(posedge CLK) begin
    if (!(mem_read || mem_write)) busy_cnt <= 0;
    else if (busy_cnt < 5)        busy_cnt <= busy_cnt + 1;
    else                          busy_cnt <= 0;
    if (mem_write && !mem_busywait) mem_model[mem_address] <= mem_writedata;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Every completed memory transfer must match the next expected one.
  always @(negedge CLK) begin
    if (!RESET && (mem_read || mem_write) && !mem_busywait) begin
      if (mem_q.size() == 0) begin
        checkOutput("mem_unexpected", mem_q.size(), 1);
      end else begin
        mem_txn_t t;
        t = mem_q.pop_front();
        checkOutput("mem_kind", {31'b0, mem_write}, {31'b0, t.wr});
        checkOutput("mem_addr", {26'b0, mem_address}, {26'b0, t.addr});
        if (t.wr) checkOutput("mem_wdata", mem_writedata, t.data);
      end
    end
  end

  task automatic pushMem(input logic wr, input logic [5:0] addr, input logic [31:0] data);
    mem_txn_t t;
    t.wr = wr;
    t.addr = addr;
    t.data = data;
    mem_q.push_back(t);
  endtask

  // Called #1 after a rising edge; returns #1 after the edge that ends the request.
  task automatic applyStimulus(input logic rd, input logic wr, input logic [7:0] addr,
                               input logic [7:0] wdata, input logic [7:0] exp_rdata,
                               input int exp_stall);
    int stall;
    READ = rd;
    WRITE = wr;
    ADDRESS = addr;
    WRITEDATA = wdata;
    if (rd && !wr) rd_q.push_back(exp_rdata);
    stall = 0;
    @(negedge CLK);
    while (BUSYWAIT && stall < 60) begin
      stall++;
      @(negedge CLK);
    end
    checkOutput("stall_cycles", stall, exp_stall);
    if (rd && !wr) checkOutput("readdata", {24'b0, READDATA}, {24'b0, rd_q.pop_front()});
    @(posedge CLK);
    #1;
    READ = 1'b0;
    WRITE = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    busy_cnt = 0;
    for (int i = 0; i < 64; i++) mem_model[i] = 32'h0;
    mem_model[6'h00] = 32'h44332211;
    mem_model[6'h08] = 32'hDDCCBBAA;
    mem_model[6'h3F] = 32'h87654321;
    mem_model[6'h11] = 32'h0BADF00D;
    READ = 1'b0;
    WRITE = 1'b0;
    WRITEDATA = 8'h00;
    ADDRESS = 8'h00;
    PC = 32'h0000_1234;
    RESET = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    RESET = 1'b0;
    @(negedge CLK);
    checkOutput("rst_busywait", {31'b0, BUSYWAIT}, 0);
    checkOutput("rst_mem_read", {31'b0, mem_read}, 0);
    checkOutput("rst_mem_write", {31'b0, mem_write}, 0);
    checkOutput("rst_readdata", {24'b0, READDATA}, 0);
    checkOutput("rst_mem_addr", {26'b0, mem_address}, 0);
    @(posedge CLK);
    #1;

    $display("[TB] cold read miss, then hits");
    pushMem(1'b0, 6'h00, 32'h0);
    applyStimulus(1'b1, 1'b0, 8'h00, 8'h00, 8'h11, 7);
    applyStimulus(1'b1, 1'b0, 8'h03, 8'h00, 8'h44, 0);
    applyStimulus(1'b0, 1'b1, 8'h01, 8'hAB, 8'h00, 0);
    applyStimulus(1'b1, 1'b0, 8'h01, 8'h00, 8'hAB, 0);

    $display("[TB] conflict miss on dirty line");
    pushMem(1'b1, 6'h00, 32'h4433AB11);
    pushMem(1'b0, 6'h08, 32'h0);
    applyStimulus(1'b1, 1'b0, 8'h20, 8'h00, 8'hAA, 13);
    applyStimulus(1'b1, 1'b0, 8'h23, 8'h00, 8'hDD, 0);

    $display("[TB] write-allocate miss");
    pushMem(1'b0, 6'h3F, 32'h0);
    applyStimulus(1'b0, 1'b1, 8'hFE, 8'h5C, 8'h00, 7);
    applyStimulus(1'b1, 1'b0, 8'hFE, 8'h00, 8'h5C, 0);
    applyStimulus(1'b1, 1'b0, 8'hFD, 8'h00, 8'h43, 0);

    $display("[TB] reset during refill");
    READ = 1'b1;
    ADDRESS = 8'h44;
    repeat (3) @(posedge CLK);
    #1;
    RESET = 1'b1;
    READ = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    checkOutput("abort_mem_read", {31'b0, mem_read}, 0);
    checkOutput("abort_busywait", {31'b0, BUSYWAIT}, 0);
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    pushMem(1'b0, 6'h11, 32'h0);
    applyStimulus(1'b1, 1'b0, 8'h44, 8'h00, 8'h0D, 7);
    pushMem(1'b0, 6'h00, 32'h0);
    applyStimulus(1'b1, 1'b0, 8'h01, 8'h00, 8'hAB, 7);

    repeat (2) @(posedge CLK);
    checkOutput("mem_q_drained", mem_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
